// File: rtl/vo_pattern_gen.sv
// vo_pattern_gen: programmable video timing and test-pattern generator.
//   Counts col/line over the programmed h/v totals and decodes sync/active
//   regions. It drives a registered gradient, colour-bar, solid or
//   checkerboard pattern, with an optional bouncing XOR cursor on top.
// Ports:
//   vo_clk, vo_reset_        pixel clock, async active-low reset
//   enable                   run timing; low holds counters at 0 and blanks
//   mode, solid_rgb          pattern select / colour for solid mode
//   cursor_en                overlay the bouncing cursor
//   vo_hsync, vo_vsync       syncs, polarity set by H_SYNC_POS / V_SYNC_POS
//   vo_blank_                high during active video
//   vo_r, vo_g, vo_b         pixel colour (0 outside active video)
//   frame_start              one-cycle pulse with the first active pixel
module vo_pattern_gen #(
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned H_FP       = 88,
  parameter int unsigned H_SYNC     = 44,
  parameter int unsigned H_BP       = 148,
  parameter int unsigned V_ACTIVE   = 1080,
  parameter int unsigned V_FP       = 4,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 36,
  parameter int unsigned H_SYNC_POS = 1,
  parameter int unsigned V_SYNC_POS = 1,
  parameter int unsigned CURSOR_W   = 50,
  parameter int unsigned CURSOR_H   = 50,
  parameter int unsigned CNTR_W     = 12
) (
  input  logic        vo_clk,
  input  logic        vo_reset_,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  input  logic        cursor_en,
  output logic        vo_hsync,
  output logic        vo_vsync,
  output logic        vo_blank_,
  output logic [7:0]  vo_r,
  output logic [7:0]  vo_g,
  output logic [7:0]  vo_b,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [CNTR_W-1:0] H_LAST   = CNTR_W'(H_TOTAL - 1);
  localparam logic [CNTR_W-1:0] V_LAST   = CNTR_W'(V_TOTAL - 1);
  localparam logic [CNTR_W-1:0] H_ACT    = CNTR_W'(H_ACTIVE);
  localparam logic [CNTR_W-1:0] V_ACT    = CNTR_W'(V_ACTIVE);
  localparam logic [CNTR_W-1:0] HS_BEG   = CNTR_W'(H_ACTIVE + H_FP);
  localparam logic [CNTR_W-1:0] HS_END   = CNTR_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNTR_W-1:0] VS_BEG   = CNTR_W'(V_ACTIVE + V_FP);
  localparam logic [CNTR_W-1:0] VS_END   = CNTR_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNTR_W-1:0] BAR_LAST = CNTR_W'(BAR_W - 1);
  localparam logic [CNTR_W:0]   CUR_W    = (CNTR_W+1)'(CURSOR_W);
  localparam logic [CNTR_W:0]   CUR_H    = (CNTR_W+1)'(CURSOR_H);
  localparam logic [CNTR_W:0]   X_LIM    = (CNTR_W+1)'(H_ACTIVE - 1);
  localparam logic [CNTR_W:0]   Y_LIM    = (CNTR_W+1)'(V_ACTIVE - 1);
  localparam logic              H_IDLE   = (H_SYNC_POS == 0);
  localparam logic              V_IDLE   = (V_SYNC_POS == 0);

  logic [CNTR_W-1:0] col_q, col_d, line_q, line_d, pix_q, pix_d;
  logic [CNTR_W-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic [2:0]        bar_q, bar_d;
  logic              x_dir_q, x_dir_d, y_dir_q, y_dir_d;
  logic [1:0]        mode_q, mode_eff;
  logic [23:0]       solid_q, solid_eff;
  logic              cur_en_q, cur_en_eff;
  logic              frame_top, active, hs, vs, hit;
  logic [CNTR_W:0]   x_end, y_end;
  logic [23:0]       bar_rgb, pat_rgb, pix_rgb;

  always_comb begin
    col_d  = '0;
    line_d = '0;
    if (enable) begin
      if (col_q == H_LAST) begin
        col_d  = '0;
        line_d = (line_q == V_LAST) ? '0 : line_q + CNTR_W'(1);
      end else begin
        col_d  = col_q + CNTR_W'(1);
        line_d = line_q;
      end
    end

    // Bar index tracks col_d so bar_q always describes the pixel at col_q;
    // bar 7 holds once reached and absorbs the H_ACTIVE % 8 remainder.
    bar_d = bar_q;
    pix_d = pix_q;
    if (col_d == '0) begin
      bar_d = '0;
      pix_d = '0;
    end else if (bar_q != 3'd7) begin
      if (pix_q == BAR_LAST) begin
        bar_d = bar_q + 3'd1;
        pix_d = '0;
      end else begin
        pix_d = pix_q + CNTR_W'(1);
      end
    end

    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    x_dir_d = x_dir_q;
    y_dir_d = y_dir_q;
    if (enable && col_q == '0 && line_q == V_ACT) begin
      if (!x_dir_q) begin
        if ({1'b0, x_pos_q} + CUR_W < X_LIM) x_pos_d = x_pos_q + CNTR_W'(1);
        else                                 x_dir_d = 1'b1;
      end else begin
        if (x_pos_q != '0) x_pos_d = x_pos_q - CNTR_W'(1);
        else               x_dir_d = 1'b0;
      end
      if (!y_dir_q) begin
        if ({1'b0, y_pos_q} + CUR_H < Y_LIM) y_pos_d = y_pos_q + CNTR_W'(1);
        else                                 y_dir_d = 1'b1;
      end else begin
        if (y_pos_q != '0) y_pos_d = y_pos_q - CNTR_W'(1);
        else               y_dir_d = 1'b0;
      end
    end
  end

  // On the frame-top cycle the live inputs are used directly, so the new
  // settings cover every pixel of the frame including pixel (0,0).
  assign frame_top  = (col_q == '0) && (line_q == '0);
  assign mode_eff   = frame_top ? mode      : mode_q;
  assign solid_eff  = frame_top ? solid_rgb : solid_q;
  assign cur_en_eff = frame_top ? cursor_en : cur_en_q;

  assign active = (col_q < H_ACT) && (line_q < V_ACT);
  assign hs     = (col_q >= HS_BEG) && (col_q < HS_END);
  assign vs     = (line_q >= VS_BEG) && (line_q < VS_END);
  assign x_end  = {1'b0, x_pos_q} + CUR_W;
  assign y_end  = {1'b0, y_pos_q} + CUR_H;
  assign hit    = (col_q >= x_pos_q) && ({1'b0, col_q} < x_end) &&
                  (line_q >= y_pos_q) && ({1'b0, line_q} < y_end);

  always_comb begin
    unique case (bar_q)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_comb begin
    unique case (mode_eff)
      2'd0:    pat_rgb = {8'hFF, line_q[4:0], 3'b000, col_q[4:0], 3'b000};
      2'd1:    pat_rgb = bar_rgb;
      2'd2:    pat_rgb = solid_eff;
      default: pat_rgb = (col_q[5] ^ line_q[5]) ? '1 : '0;
    endcase
    if (!(active && enable))   pix_rgb = '0;
    else if (cur_en_eff && hit) pix_rgb = ~pat_rgb;
    else                        pix_rgb = pat_rgb;
  end

  always_ff @(posedge vo_clk or negedge vo_reset_) begin
    if (!vo_reset_) begin
      col_q       <= '0;
      line_q      <= '0;
      bar_q       <= '0;
      pix_q       <= '0;
      x_pos_q     <= '0;
      y_pos_q     <= '0;
      x_dir_q     <= 1'b0;
      y_dir_q     <= 1'b0;
      mode_q      <= '0;
      solid_q     <= '0;
      cur_en_q    <= 1'b0;
      vo_hsync    <= H_IDLE;
      vo_vsync    <= V_IDLE;
      vo_blank_   <= 1'b0;
      vo_r        <= '0;
      vo_g        <= '0;
      vo_b        <= '0;
      frame_start <= 1'b0;
    end else begin
      col_q   <= col_d;
      line_q  <= line_d;
      bar_q   <= bar_d;
      pix_q   <= pix_d;
      x_pos_q <= x_pos_d;
      y_pos_q <= y_pos_d;
      x_dir_q <= x_dir_d;
      y_dir_q <= y_dir_d;
      if (frame_top) begin
        mode_q   <= mode;
        solid_q  <= solid_rgb;
        cur_en_q <= cursor_en;
      end
      // Region outputs are gated with enable so the idle (0,0) counter
      // state never presents as active video.
      vo_hsync             <= (hs && enable) ^ H_IDLE;
      vo_vsync             <= (vs && enable) ^ V_IDLE;
      vo_blank_            <= active && enable;
      {vo_r, vo_g, vo_b}   <= pix_rgb;
      frame_start          <= frame_top && enable;
    end
  end

endmodule

// File: tb/tb_vo_pattern_gen.sv
// Directed bench for vo_pattern_gen. DUT A: 16x8 active, totals 23x12,
// positive syncs, 2x2 cursor. DUT B: 44x8 active, totals 51x12, negative
// syncs, used for colour bars (5-pixel bars, 9-pixel last bar) and checker.
module tb_vo_pattern_gen;

  logic        vo_clk = 1'b0;
  logic        vo_reset_ = 1'b0;
  logic        enable, en_b;
  logic [1:0]  mode, mode_b;
  logic [23:0] solid, solid_b;
  logic        cursor_en, cursor_en_b;

  logic        hs_a, vs_a, blank_a, fs_a, hs_b, vs_b, blank_b, fs_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic [23:0] rgb_a, rgb_b;

  int cyc, a0, b0, n_vec, n_bad;

  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};

  always #5 vo_clk = ~vo_clk;

  vo_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POS(1), .V_SYNC_POS(1),
    .CURSOR_W(2), .CURSOR_H(2), .CNTR_W(12)
  ) dut_a (
    .vo_clk(vo_clk), .vo_reset_(vo_reset_), .enable(enable), .mode(mode),
    .solid_rgb(solid), .cursor_en(cursor_en),
    .vo_hsync(hs_a), .vo_vsync(vs_a), .vo_blank_(blank_a),
    .vo_r(r_a), .vo_g(g_a), .vo_b(b_a), .frame_start(fs_a)
  );

  vo_pattern_gen #(
    .H_ACTIVE(44), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POS(0), .V_SYNC_POS(0),
    .CURSOR_W(2), .CURSOR_H(2), .CNTR_W(12)
  ) dut_b (
    .vo_clk(vo_clk), .vo_reset_(vo_reset_), .enable(en_b), .mode(mode_b),
    .solid_rgb(solid_b), .cursor_en(cursor_en_b),
    .vo_hsync(hs_b), .vo_vsync(vs_b), .vo_blank_(blank_b),
    .vo_r(r_b), .vo_g(g_b), .vo_b(b_b), .frame_start(fs_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge vo_clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  // Advance until the outputs show pixel p counted from the enable rise.
  task automatic at_a(input int p);
    tick_to(a0 + 1 + p);
  endtask

  task automatic at_b(input int q);
    tick_to(b0 + 1 + q);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b0; en_b = 1'b0;
    mode = 2'd0; solid = 24'h123456; cursor_en = 1'b0;
    mode_b = 2'd1; solid_b = '0; cursor_en_b = 1'b0;
    cyc = 0; n_vec = 0; n_bad = 0;

    tick(); tick();
    check_eq("rst_hs_a",    32'(hs_a),    32'd0);
    check_eq("rst_vs_a",    32'(vs_a),    32'd0);
    check_eq("rst_blank_a", 32'(blank_a), 32'd0);
    check_eq("rst_rgb_a",   32'(rgb_a),   32'h0);
    check_eq("rst_fs_a",    32'(fs_a),    32'd0);
    check_eq("rst_hs_b",    32'(hs_b),    32'd1);
    check_eq("rst_vs_b",    32'(vs_b),    32'd1);
    check_eq("rst_blank_b", 32'(blank_b), 32'd0);

    vo_reset_ = 1'b1;
    enable = 1'b1;
    a0 = cyc;

    // Frame 0, gradient
    at_a(0);
    check_eq("a_fs_p0",    32'(fs_a),    32'd1);
    check_eq("a_blank_p0", 32'(blank_a), 32'd1);
    check_eq("a_rgb_p0",   32'(rgb_a),   32'hFF0000);
    check_eq("a_hs_p0",    32'(hs_a),    32'd0);
    at_a(1);
    check_eq("a_fs_p1",    32'(fs_a),    32'd0);
    check_eq("a_rgb_p1",   32'(rgb_a),   32'hFF0008);
    at_a(15);
    check_eq("a_rgb_c15",  32'(rgb_a),   32'hFF0078);
    check_eq("a_blank_c15", 32'(blank_a), 32'd1);
    at_a(16);
    check_eq("a_blank_c16", 32'(blank_a), 32'd0);
    check_eq("a_rgb_c16",  32'(rgb_a),   32'h0);
    at_a(17);
    check_eq("a_hs_c17",   32'(hs_a),    32'd0);
    at_a(18);
    check_eq("a_hs_c18",   32'(hs_a),    32'd1);
    check_eq("b_idle_hs",  32'(hs_b),    32'd1);
    check_eq("b_idle_vs",  32'(vs_b),    32'd1);
    check_eq("b_idle_blank", 32'(blank_b), 32'd0);
    at_a(20);
    check_eq("a_hs_c20",   32'(hs_a),    32'd1);
    at_a(21);
    check_eq("a_hs_c21",   32'(hs_a),    32'd0);
    at_a(73);
    check_eq("a_rgb_l3c4", 32'(rgb_a),   32'hFF1820);
    mode = 2'd2;
    at_a(117);
    check_eq("a_rgb_l5c2_hold", 32'(rgb_a), 32'hFF2810);
    at_a(184);
    check_eq("a_blank_l8", 32'(blank_a), 32'd0);
    check_eq("a_vs_l8",    32'(vs_a),    32'd0);
    at_a(207);
    check_eq("a_vs_l9",    32'(vs_a),    32'd1);
    at_a(252);
    check_eq("a_vs_l10c22", 32'(vs_a),   32'd1);
    at_a(253);
    check_eq("a_vs_l11",   32'(vs_a),    32'd0);

    // Frame 1, solid 123456 picked up at the frame boundary
    at_a(276);
    check_eq("a_fs_f1",    32'(fs_a),    32'd1);
    check_eq("a_rgb_f1p0", 32'(rgb_a),   32'h123456);
    at_a(325);
    check_eq("a_rgb_f1l2c3", 32'(rgb_a), 32'h123456);
    solid = 24'h000000;
    cursor_en = 1'b1;

    // Frame 2: cursor at (2,2) over black
    at_a(599);
    check_eq("a_cur_f2_c1",  32'(rgb_a), 32'h0);
    at_a(600);
    check_eq("a_cur_f2_c2",  32'(rgb_a), 32'hFFFFFF);
    at_a(602);
    check_eq("a_cur_f2_c4",  32'(rgb_a), 32'h0);
    at_a(624);
    check_eq("a_cur_f2_l3c3", 32'(rgb_a), 32'hFFFFFF);
    at_a(646);
    check_eq("a_cur_f2_l4c2", 32'(rgb_a), 32'h0);
    // Frame 6: y held at 5 after bottom bounce; frame 7: y=4
    at_a(1777);
    check_eq("a_cur_f6_6_5", 32'(rgb_a), 32'hFFFFFF);
    at_a(2031);
    check_eq("a_cur_f7_7_4", 32'(rgb_a), 32'hFFFFFF);
    at_a(2077);
    check_eq("a_cur_f7_7_6", 32'(rgb_a), 32'h0);
    // Frames 13/14/15: x = 13, 13 (turn, hold), 12
    at_a(3623);
    check_eq("a_cur_f13_12_1", 32'(rgb_a), 32'h0);
    at_a(3624);
    check_eq("a_cur_f13_13_1", 32'(rgb_a), 32'hFFFFFF);
    at_a(3922);
    check_eq("a_cur_f14_12_2", 32'(rgb_a), 32'h0);
    at_a(3924);
    check_eq("a_cur_f14_14_2", 32'(rgb_a), 32'hFFFFFF);
    at_a(4221);
    check_eq("a_cur_f15_12_3", 32'(rgb_a), 32'hFFFFFF);
    at_a(4223);
    check_eq("a_cur_f15_14_3", 32'(rgb_a), 32'h0);

    // DUT B: colour bars in frame 0, checkerboard in frame 1
    en_b = 1'b1;
    b0 = cyc;
    at_b(0);
    check_eq("b_fs_p0",    32'(fs_b),    32'd1);
    check_eq("b_bar_c0",   32'(rgb_b),   32'hFFFFFF);
    at_b(4);
    check_eq("b_bar_c4",   32'(rgb_b),   32'hFFFFFF);
    at_b(5);
    check_eq("b_bar_c5",   32'(rgb_b),   32'hFFFF00);
    at_b(12);
    check_eq("b_bar_c12",  32'(rgb_b),   32'h00FFFF);
    at_b(17);
    check_eq("b_bar_c17",  32'(rgb_b),   32'h00FF00);
    at_b(22);
    check_eq("b_bar_c22",  32'(rgb_b),   32'hFF00FF);
    at_b(27);
    check_eq("b_bar_c27",  32'(rgb_b),   32'hFF0000);
    at_b(34);
    check_eq("b_bar_c34",  32'(rgb_b),   32'h0000FF);
    at_b(35);
    check_eq("b_bar_c35",  32'(rgb_b),   32'h000000);
    at_b(40);
    check_eq("b_bar_c40",  32'(rgb_b),   32'h000000);
    at_b(43);
    check_eq("b_blank_c43", 32'(blank_b), 32'd1);
    at_b(44);
    check_eq("b_blank_c44", 32'(blank_b), 32'd0);
    at_b(45);
    check_eq("b_hs_c45",   32'(hs_b),    32'd1);
    at_b(46);
    check_eq("b_hs_c46",   32'(hs_b),    32'd0);
    at_b(48);
    check_eq("b_hs_c48",   32'(hs_b),    32'd0);
    at_b(49);
    check_eq("b_hs_c49",   32'(hs_b),    32'd1);
    at_b(56);
    check_eq("b_bar_l1c5", 32'(rgb_b),   32'hFFFF00);
    mode_b = 2'd3;
    at_b(408);
    check_eq("b_vs_l8",    32'(vs_b),    32'd1);
    at_b(459);
    check_eq("b_vs_l9",    32'(vs_b),    32'd0);
    at_b(643);
    check_eq("b_chk_c31",  32'(rgb_b),   32'h000000);
    at_b(644);
    check_eq("b_chk_c32",  32'(rgb_b),   32'hFFFFFF);
    at_b(877);
    check_eq("b_chk_l5c10", 32'(rgb_b),  32'h000000);
    at_b(900);
    check_eq("b_chk_l5c33", 32'(rgb_b),  32'hFFFFFF);

    // Disable A, then restart from (0,0)
    enable = 1'b0;
    tick(); tick();
    check_eq("a_dis_blank", 32'(blank_a), 32'd0);
    check_eq("a_dis_hs",    32'(hs_a),    32'd0);
    check_eq("a_dis_rgb",   32'(rgb_a),   32'h0);
    check_eq("a_dis_fs",    32'(fs_a),    32'd0);
    enable = 1'b1;
    a0 = cyc;
    at_a(0);
    check_eq("a_ren_fs",    32'(fs_a),    32'd1);
    check_eq("a_ren_blank", 32'(blank_a), 32'd1);
    at_a(1);
    check_eq("a_ren_fs1",   32'(fs_a),    32'd0);

    // Asynchronous reset in the middle of line 2
    at_a(2 * 23 + 7);
    #2 vo_reset_ = 1'b0;
    #1;
    check_eq("mrst_blank_a", 32'(blank_a), 32'd0);
    check_eq("mrst_rgb_a",   32'(rgb_a),   32'h0);
    check_eq("mrst_hs_a",    32'(hs_a),    32'd0);
    check_eq("mrst_fs_a",    32'(fs_a),    32'd0);
    check_eq("mrst_hs_b",    32'(hs_b),    32'd1);
    check_eq("mrst_vs_b",    32'(vs_b),    32'd1);
    #2 vo_reset_ = 1'b1;
    a0 = cyc;
    at_a(0);
    check_eq("post_fs_a",    32'(fs_a),    32'd1);
    check_eq("post_fs_b",    32'(fs_b),    32'd1);
    check_eq("post_rgb_c0",  32'(rgb_a),   32'hFFFFFF);
    at_a(1);
    check_eq("post_rgb_c1",  32'(rgb_a),   32'hFFFFFF);
    at_a(2);
    check_eq("post_rgb_c2",  32'(rgb_a),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
